sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares one SRAM-like memory port between the core's instruction-fetch side and data-access side. It sits between the core's fetch and memory stages and the bus bridge. It arbitrates per transaction, with data priority and an instruction-starvation guard, and keeps exactly one transaction outstanding. It also drives a stall request into the pipeline stall controller while a data access is unresolved.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width; `DATA_W/8` byte strobes.
- `STARVE_MAX`, default 4, consecutive data grants allowed while an instruction request waits (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_req`  in  1  fetch request, held until `inst_addr_ok`.
- `inst_addr`  in  ADDR_W  fetch address.
- `inst_addr_ok`  out  1  fetch request accepted this cycle.
- `inst_data_ok`  out  1  fetch data valid this cycle.
- `inst_rdata`  out  DATA_W  fetch data.
- `data_req`  in  1  load/store request, held until `data_addr_ok`.
- `data_wr`  in  1  1 = store.
- `data_wstrb`  in  DATA_W/8  byte enables for stores.
- `data_addr`  in  ADDR_W  access address.
- `data_wdata`  in  DATA_W  store data.
- `data_addr_ok`  out  1  access accepted this cycle.
- `data_data_ok`  out  1  load data valid, or store complete, this cycle.
- `data_rdata`  out  DATA_W  load data.
- `mem_req`  out  1  memory request.
- `mem_wr`  out  1  write flag.
- `mem_wstrb`  out  DATA_W/8  byte strobes; 0 on reads.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_addr_ok`  in  1  memory accepted the request.
- `mem_data_ok`  in  1  memory response.
- `mem_rdata`  in  DATA_W  memory read data.
- `stallreq_mem`  out  1  stall request to the stall controller.

## Operation
- FSM states:
  - `IDLE`: arbitrate.
  - `ADDR`: `mem_req`=1 from latched fields; hold until `mem_addr_ok`.
  - `RESP`: wait for `mem_data_ok`.
- In `IDLE`, grant rules:
  - Only `data_req`: data wins.
  - Only `inst_req`: inst wins.
  - Both: data wins unless `streak` == `STARVE_MAX`, in which case inst wins.
- On grant:
  - Pulse the winner's `*_addr_ok` combinationally in the same cycle.
  - Latch addr, wr, wstrb, wdata and the `owner` bit.
  - Go to `ADDR`.
  - For inst grants, latch `wr`=0 and `wstrb`=0.
- `ADDR` → `RESP` on `mem_addr_ok`.
- `RESP` → `IDLE` on `mem_data_ok`.
  - In that cycle, `<owner>_data_ok`=1 and `<owner>_rdata`=`mem_rdata`, combinationally.
  - The non-owner's `*_data_ok` stays 0.
- `streak`, width clog2(`STARVE_MAX`+1):
  - +1 on a data grant while `inst_req`=1, saturating at `STARVE_MAX`.
  - Cleared on any inst grant.
  - Unchanged on a data grant with `inst_req`=0.
- `stallreq_mem` = (`data_req` & ~`data_addr_ok`) | (state≠`IDLE` & `owner`=data & ~`data_data_ok`).
- `mem_data_ok` outside `RESP` is ignored; no requester sees it.
- `mem_addr_ok` outside `ADDR` is ignored.
- No new grant in the cycle the FSM returns to `IDLE`. The next grant is one cycle later, which gives a registered, glitch-free `mem_req`.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - State `IDLE`, `streak`=0, `owner`=inst.
  - All latched fields 0, so `mem_req`=`mem_wr`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
  - Every `*_addr_ok` and `*_data_ok` output is 0 and `stallreq_mem`=0 while reset is held.
- Reset mid-transaction drops the transaction. A later `mem_data_ok` arrives in `IDLE` and is discarded.
- Best-case latency:
  - Grant in cycle 0.
  - `mem_req` in cycle 1, `mem_addr_ok` in cycle 1.
  - `mem_data_ok` in cycle 2, `*_data_ok` in cycle 2.
  - Next grant possible in cycle 3.
- `mem_req` and the latched fields stay stable from cycle 1 until `mem_addr_ok`.
- Requesters must hold their inputs until `*_addr_ok`. The arbiter does not sample them after the grant.

## Structure
- Shared package (`lib/defines.vh`) holds:
  - State encodings `ARB_IDLE`/`ARB_ADDR`/`ARB_RESP`.
  - Owner encoding `OWN_INST`/`OWN_DATA`.
  - Default `STARVE_MAX`.
- One sub-module, `arb_pick`: combinational priority-plus-starvation selector. Inputs are both requests and `streak`; outputs are the grant bits.
- The core top wires `stallreq_mem` into the stall controller alongside the existing ID and EX stall requests.

## Test plan
- Lone fetch: `inst_req`=1, addr 0xBFC00000. Expect `inst_addr_ok` in cycle 0 and `mem_req`/`mem_addr`=0xBFC00000 in cycle 1. Memory returns 0x24010001, so `inst_data_ok`=1 and `inst_rdata`=0x24010001; `data_data_ok` stays 0.
- Simultaneous requests: inst 0x100, data store 0x200, wstrb 0xF, wdata 0xDEADBEEF. Expect data granted first with `mem_wr`=1 and `mem_wstrb`=0xF; inst granted in the next `IDLE` grant cycle.
- Starvation: `data_req` and `inst_req` held continuously with `STARVE_MAX`=4. Expect exactly 4 data grants, then 1 inst grant, and `streak` back at 0.
- Slow memory: `mem_addr_ok` delayed 3 cycles and `mem_data_ok` delayed 5. Expect `mem_req` and `mem_addr` stable throughout, and `stallreq_mem`=1 until `data_data_ok`.
- Reset mid-`RESP`: assert `rst`=0, then inject `mem_data_ok`=1 after release. Expect no `*_data_ok` pulse and `mem_req`=0 immediately on reset.
- Spurious `mem_data_ok` in `IDLE` with no requests: expect all outputs to stay 0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, transaction owner
// and the default starvation limit.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int STARVE_MAX_DEFAULT = 4;

  // Streak counter must hold 0..max inclusive.
  function automatic int streak_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_pick.sv
// Combinational selector: data has priority unless the instruction side has
// already waited through STARVE_MAX consecutive data grants.
module arb_pick
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int SW         = 3
) (
  input  logic          inst_req,
  input  logic          data_req,
  input  logic [SW-1:0] streak,
  output logic          grant_inst,
  output logic          grant_data
);

  logic starved;

  assign starved = (streak == SW'(STARVE_MAX));

  always_comb begin
    grant_data = data_req & ~(inst_req & starved);
    grant_inst = inst_req & ~grant_data;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// one transaction outstanding, data priority with an inst starvation guard.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               inst_req,
  input  logic [ADDR_W-1:0]                  inst_addr,
  output logic                               inst_addr_ok,
  output logic                               inst_data_ok,
  output logic [DATA_W-1:0]                  inst_rdata,
  input  logic                               data_req,
  input  logic                               data_wr,
  input  logic [DATA_W/8-1:0]                data_wstrb,
  input  logic [ADDR_W-1:0]                  data_addr,
  input  logic [DATA_W-1:0]                  data_wdata,
  output logic                               data_addr_ok,
  output logic                               data_data_ok,
  output logic [DATA_W-1:0]                  data_rdata,
  output logic                               mem_req,
  output logic                               mem_wr,
  output logic [DATA_W/8-1:0]                mem_wstrb,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic                               mem_addr_ok,
  input  logic                               mem_data_ok,
  input  logic [DATA_W-1:0]                  mem_rdata,
  output logic                               stallreq_mem,
  output logic [1:0]                         dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]    dbg_streak
);

  localparam int SW = streak_width(STARVE_MAX);

  // Handshake: a requester holds *_req and its fields until *_addr_ok is seen
  // high in the same cycle; *_data_ok is a single-cycle pulse with rdata valid.
  arb_state_t           state;
  owner_t               owner;
  logic [SW-1:0]        streak;
  logic                 mem_req_q;
  logic                 lat_wr;
  logic [DATA_W/8-1:0]  lat_wstrb;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DATA_W-1:0]    lat_wdata;

  logic pick_inst;
  logic pick_data;
  logic idle;
  logic resp_done;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .streak     (streak),
    .grant_inst (pick_inst),
    .grant_data (pick_data)
  );

  // rst is folded in so no handshake output can fire while reset is held.
  assign idle      = (state == ARB_IDLE) & rst;
  assign resp_done = (state == ARB_RESP) & mem_data_ok;

  assign inst_addr_ok = idle & pick_inst;
  assign data_addr_ok = idle & pick_data;
  assign inst_data_ok = resp_done & (owner == OWN_INST);
  assign data_data_ok = resp_done & (owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  assign stallreq_mem = rst & ((data_req & ~data_addr_ok) |
                               ((state != ARB_IDLE) & (owner == OWN_DATA) & ~data_data_ok));

  assign mem_req   = mem_req_q;
  assign mem_wr    = lat_wr;
  assign mem_wstrb = lat_wstrb;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign dbg_state  = state;
  assign dbg_streak = streak;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_INST;
      streak    <= '0;
      mem_req_q <= 1'b0;
      lat_wr    <= 1'b0;
      lat_wstrb <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (data_addr_ok) begin
            state     <= ARB_ADDR;
            mem_req_q <= 1'b1;
            owner     <= OWN_DATA;
            lat_addr  <= data_addr;
            lat_wr    <= data_wr;
            lat_wstrb <= data_wr ? data_wstrb : '0;
            lat_wdata <= data_wdata;
            if (inst_req && (streak != SW'(STARVE_MAX)))
              streak <= streak + SW'(1);
          end else if (inst_addr_ok) begin
            state     <= ARB_ADDR;
            mem_req_q <= 1'b1;
            owner     <= OWN_INST;
            lat_addr  <= inst_addr;
            lat_wr    <= 1'b0;
            lat_wstrb <= '0;
            lat_wdata <= '0;
            streak    <= '0;
          end
        end
        ARB_ADDR: begin
          if (mem_addr_ok) begin
            state     <= ARB_RESP;
            mem_req_q <= 1'b0;
          end
        end
        ARB_RESP: begin
          // Returning to IDLE takes a full cycle before the next grant.
          if (mem_data_ok)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: fetch, contention, starvation guard, slow
// memory, reset mid-transaction and spurious memory responses.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_streak;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .stallreq_mem (stallreq_mem),
    .dbg_state    (dbg_state),
    .dbg_streak   (dbg_streak)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with requests already driven; returns at the next negedge.
  task automatic expect_grant(input string tag, input logic exp_data);
    #1;
    check_eq({tag, "_data_addr_ok"}, data_addr_ok, exp_data);
    check_eq({tag, "_inst_addr_ok"}, inst_addr_ok, !exp_data);
    check_eq({tag, "_stall_at_grant"}, stallreq_mem, exp_data ? 1'b0 : data_req);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory side of one transaction, starting at the negedge after the grant.
  task automatic serve(input int a_dly, input int d_dly, input logic own_data,
                       input logic [31:0] e_addr, input logic e_wr, input logic [3:0] e_wstrb,
                       input logic [31:0] e_wdata, input logic [31:0] rdata);
    logic [31:0] exp_rd;
    for (int i = 0; i < a_dly; i++) begin
      mem_addr_ok = 1'b0;
      #1;
      check_eq("addr_wait_mem_req", mem_req, 1'b1);
      check_eq("addr_wait_mem_addr", mem_addr, e_addr);
      check_eq("addr_wait_stall", stallreq_mem, own_data | data_req);
      @(posedge clk);
      @(negedge clk);
    end
    mem_addr_ok = 1'b1;
    #1;
    check_eq("mem_req", mem_req, 1'b1);
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_wr", mem_wr, e_wr);
    check_eq("mem_wstrb", mem_wstrb, e_wstrb);
    check_eq("mem_wdata", mem_wdata, e_wdata);
    check_eq("addr_stall", stallreq_mem, own_data | data_req);
    @(posedge clk);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    for (int i = 0; i < d_dly; i++) begin
      #1;
      check_eq("resp_wait_mem_req", mem_req, 1'b0);
      check_eq("resp_wait_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      check_eq("resp_wait_stall", stallreq_mem, own_data | data_req);
      @(posedge clk);
      @(negedge clk);
    end
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    exp_q.push_back(rdata);
    #1;
    exp_rd = exp_q.pop_front();
    check_eq("inst_data_ok", inst_data_ok, !own_data);
    check_eq("data_data_ok", data_data_ok, own_data);
    check_eq("owner_rdata", own_data ? data_rdata : inst_rdata, exp_rd);
    check_eq("no_grant_on_return", {inst_addr_ok, data_addr_ok}, 2'b00);
    check_eq("return_stall", stallreq_mem, data_req);
    @(posedge clk);
    @(negedge clk);
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  initial begin
    rst = 1'b0;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;

    // Reset values, with requests pending while reset is held
    #2;
    inst_req = 1; data_req = 1;
    #1;
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_wr", mem_wr, 1'b0);
    check_eq("rst_mem_wstrb", mem_wstrb, 4'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check_eq("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check_eq("rst_stall", stallreq_mem, 1'b0);
    check_eq("rst_state", dbg_state, 2'd0);
    check_eq("rst_streak", dbg_streak, 3'd0);
    inst_req = 0; data_req = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Spurious memory handshakes in IDLE with no requests
    mem_data_ok = 1; mem_addr_ok = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check_eq("spur_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check_eq("spur_rdata", {inst_rdata, data_rdata}, 64'h0);
    check_eq("spur_mem_req", mem_req, 1'b0);
    check_eq("spur_stall", stallreq_mem, 1'b0);
    @(posedge clk);
    @(negedge clk);
    mem_data_ok = 0; mem_addr_ok = 0; mem_rdata = '0;
    #1;
    check_eq("spur_state", dbg_state, 2'd0);
    @(negedge clk);

    // Lone fetch
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    expect_grant("fetch", 1'b0);
    inst_req = 0;
    serve(0, 0, 1'b0, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h2401_0001);

    // Simultaneous: data store first, inst at the next grant opportunity
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wr = 1; data_addr = 32'h200; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    expect_grant("sim_data", 1'b1);
    check_eq("sim_streak1", dbg_streak, 3'd1);
    data_req = 0;
    serve(0, 0, 1'b1, 32'h200, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h1111_1111);
    expect_grant("sim_inst", 1'b0);
    check_eq("sim_streak0", dbg_streak, 3'd0);
    inst_req = 0;
    serve(0, 0, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 32'hCAFE_F00D);

    // Starvation guard: both held, expect 4 data reads then 1 fetch
    data_req = 1; data_wr = 0; data_addr = 32'h500; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    inst_req = 1; inst_addr = 32'h600;
    for (int i = 0; i < 5; i++) begin
      logic is_data;
      is_data = (i < 4);
      expect_grant("starve", is_data);
      check_eq("starve_streak", dbg_streak, is_data ? 3'(i + 1) : 3'd0);
      if (!is_data) begin
        inst_req = 0; data_req = 0;
      end
      serve(0, 0, is_data, is_data ? 32'h500 : 32'h600, 1'b0, 4'h0,
            is_data ? 32'h1234_5678 : 32'h0, 32'hA0 + 32'(i));
    end

    // Slow memory, partial store
    data_req = 1; data_wr = 1; data_addr = 32'h300; data_wstrb = 4'b0011; data_wdata = 32'h0BAD_F00D;
    expect_grant("slow", 1'b1);
    data_req = 0;
    serve(3, 5, 1'b1, 32'h300, 1'b1, 4'b0011, 32'h0BAD_F00D, 32'h0);

    // Reset while waiting for the response
    data_req = 1; data_wr = 0; data_addr = 32'h400; data_wstrb = 4'h0;
    expect_grant("mid_rst", 1'b1);
    data_req = 0;
    mem_addr_ok = 1;
    #1;
    @(posedge clk);
    @(negedge clk);
    mem_addr_ok = 0;
    #1;
    check_eq("mid_rst_in_resp", dbg_state, 2'd2);
    data_req = 1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_mem_req", mem_req, 1'b0);
    check_eq("mid_rst_mem_addr", mem_addr, 32'h0);
    check_eq("mid_rst_state", dbg_state, 2'd0);
    check_eq("mid_rst_stall", stallreq_mem, 1'b0);
    check_eq("mid_rst_addr_ok", data_addr_ok, 1'b0);
    @(posedge clk);
    @(negedge clk);
    data_req = 0;
    rst = 1'b1;
    @(negedge clk);
    mem_data_ok = 1; mem_rdata = 32'h55;
    #1;
    check_eq("late_resp_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check_eq("late_resp_rdata", data_rdata, 32'h0);
    check_eq("late_resp_mem_req", mem_req, 1'b0);
    @(posedge clk);
    @(negedge clk);
    mem_data_ok = 0; mem_rdata = '0;
    #1;
    check_eq("late_resp_state", dbg_state, 2'd0);
    check_eq("late_resp_mem_req2", mem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
